// File: rtl/regfile_if.sv
// Register file port bundle: one write request from MEM/WB, two read ports to decode.
// Reads are combinational and zero-latency, and there is no backpressure: the file accepts one write per cycle.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output we, waddr, wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile.sv
// RISC-V integer register file: 31 stored registers, x0 reads as zero, two read ports with write bypass.
// Write latency 1 cycle, read latency 0 cycles (bypass in the same cycle), no backpressure.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    logic [DATA_W-1:0] regs [1:NREG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && bus.waddr != '0) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Enables and the x0 check gate the array index, so unused ports drive exact zeros.
    always_comb begin
        bus.rdata1 = '0;
        if (rst || !bus.re1 || bus.raddr1 == '0) begin
            bus.rdata1 = '0;
        end else if (bus.we && bus.waddr == bus.raddr1) begin
            bus.rdata1 = bus.wdata;
        end else begin
            bus.rdata1 = regs[bus.raddr1];
        end
    end

    always_comb begin
        bus.rdata2 = '0;
        if (rst || !bus.re2 || bus.raddr2 == '0) begin
            bus.rdata2 = '0;
        end else if (bus.we && bus.waddr == bus.raddr2) begin
            bus.rdata2 = bus.wdata;
        end else begin
            bus.rdata2 = regs[bus.raddr2];
        end
    end

endmodule

// File: doc/regfile.md
# regfile

Integer register file for the RISC-V core: 32 x 32-bit architectural registers, x0 hardwired to zero. Sits at the far end of the execute result path. The destination address, write flag and result data produced by execute arrive here through the MEM/WB pipeline as a write request. Two combinational read ports with same-cycle write bypass feed the decode stage, which supplies execute's operands.

## Interface

- DATA_W, 32, register and data width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- NREG, 32, number of architectural registers (2**ADDR_W)

- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high (RstEnable = 1)
- we  input  1  write enable (the wreg flag forwarded from MEM/WB)
- waddr  input  ADDR_W  destination register (wd forwarded from MEM/WB)
- wdata  input  DATA_W  result to write (wdata forwarded from MEM/WB)
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data, combinational
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data, combinational

## Operation

- Storage: regs[1..NREG-1], DATA_W each. There is no storage for x0.
- Write, evaluated at each rising clk edge:
  - rst=1: every regs[i] is cleared to 0, and any write request in that cycle is discarded.
  - rst=0, we=1, waddr!=0: regs[waddr] <= wdata.
  - we=1 with waddr=0: no state change.
  - we=0: no state change.
- Read port n (n = 1, 2) is purely combinational. Priority, first match wins:
  1. rst=1 -> 0
  2. re_n=0 -> 0
  3. raddr_n=0 -> 0
  4. we=1 and waddr=raddr_n -> wdata (bypass)
  5. otherwise -> regs[raddr_n]
- The bypass covers the write-back-to-decode hazard. Decode sees a value in the same cycle it is being written. The next cycle it reads the same value from storage, so there is no glitch or gap.
- Both ports are independent. Both may address the same register, and both may hit the bypass at once.
- No X propagation: the enables gate the array indexing, so an unused port outputs exactly 0.

## Timing

- Write latency: 1 cycle. Data is visible from storage in the cycle after the edge, and through the bypass in the same cycle.
- Read latency: 0 cycles. The combinational path runs from raddr, re, we, waddr and wdata to rdata.
- Reset is synchronous. rst asserted mid-stream clears all registers at the next edge. While rst=1, rdata1 and rdata2 are 0 regardless of other inputs. Data is readable again in the first cycle with rst=0.
- Reset values: all registers 0, and rdata1 = rdata2 = 0.
- Back-to-back writes to the same address are allowed. The last edge wins.
- Write with simultaneous reset: reset wins and the register stays 0.
- A write of 0 to a register is a normal write. It is not treated as no-op.

## Test plan

- Reset: preload x5=0xDEADBEEF, assert rst for one edge, release -> read x5 returns 0x00000000. During rst, rdata1 and rdata2 are 0 even with re=1 and a bypass hit.
- Basic write/read: write x3=0x12345678, then next cycle re1=1, raddr1=3 -> rdata1=0x12345678. With re1=0 -> rdata1=0.
- x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF, then read x0 on both ports -> 0 in the same cycle and the next cycle.
- Bypass: x7 holds 0x11111111. In one cycle drive we=1, waddr=7, wdata=0x22222222 with raddr1=raddr2=7, re1=re2=1 -> both rdata=0x22222222 in that cycle and in the following cycle with we=0.
- Dual port, different addresses: write x1=0xA, x31=0xB, then read raddr1=31, raddr2=1 -> rdata1=0xB, rdata2=0xA. Then write x31=0xC while reading x1 on port 2 -> rdata2 stays 0xA.
- Write blocked by reset: in the same cycle assert rst=1, we=1, waddr=9, wdata=0x55 -> after release, x9 reads 0.
